// File: rtl/keypad_scanner_pkg.sv
// Shared types and key codes for the 4x4 keypad scanner and the game core that consumes it.
package keypad_scanner_pkg;

  typedef enum logic {
    StIdle,
    StHeld
  } state_e;

  typedef enum logic [1:0] {
    SwNone,
    SwSingle,
    SwMulti
  } sweep_e;

  localparam logic [3:0] KEY_RIGHT = 4'h2;
  localparam logic [3:0] KEY_DOWN  = 4'h4;
  localparam logic [3:0] KEY_UP    = 4'h6;
  localparam logic [3:0] KEY_LEFT  = 4'h8;

  // Number of active-low bits in a row sample.
  function automatic logic [2:0] count_low(input logic [3:0] rows);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (!rows[i]) cnt = cnt + 3'd1;
    end
    return cnt;
  endfunction

  // Index of the lowest active-low bit; only meaningful when exactly one bit is low.
  function automatic logic [1:0] low_idx(input logic [3:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad row lines.
module keypad_scanner_sync2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 4'hF;
      r_sync <= 4'hF;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with sweep-level debounce; emits one pulse per accepted press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES = 50000,
  parameter int unsigned DEB_SCANS   = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_row_in,
  output logic [3:0] o_col_out,
  output logic [3:0] o_key_val,
  output logic       o_key_pressed,
  output logic       o_key_held
);

  localparam int unsigned ScanW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned DebW  = $clog2(DEB_SCANS + 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_CYCLES - 1);
  localparam logic [DebW-1:0]  DebMax   = DebW'(DEB_SCANS);

  logic [3:0]       w_rows;
  logic [ScanW-1:0] r_scan_cnt;
  logic [1:0]       r_col_idx;
  logic             w_sample;
  logic             w_sweep_end;

  sweep_e           r_acc_kind;
  sweep_e           w_acc_kind;
  logic [3:0]       r_acc_code;
  logic [3:0]       w_acc_code;
  logic [2:0]       w_nlow;

  logic             w_res_single;
  logic             w_same;
  logic             r_cand_single;
  logic [3:0]       r_cand_code;
  logic [DebW-1:0]  r_match_cnt;
  logic             w_deb_done;

  state_e           r_state;
  state_e           w_state_d;
  logic [3:0]       r_key_val;
  logic [3:0]       w_key_val_d;
  logic             r_key_pressed;
  logic             w_key_pressed_d;

  keypad_scanner_sync2 u_sync2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_row_in),
    .o_q     (w_rows)
  );

  assign w_sample    = (r_scan_cnt == ScanLast);
  assign w_sweep_end = w_sample && (r_col_idx == 2'd3);
  assign w_nlow      = count_low(w_rows);

  // Running sweep classification, including the column currently being sampled.
  always_comb begin
    w_acc_kind = r_acc_kind;
    w_acc_code = r_acc_code;
    if (w_nlow >= 3'd2) begin
      w_acc_kind = SwMulti;
    end else if (w_nlow == 3'd1) begin
      if (r_acc_kind == SwNone) begin
        w_acc_kind = SwSingle;
        w_acc_code = {low_idx(w_rows), r_col_idx};
      end else begin
        w_acc_kind = SwMulti;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scan_cnt <= '0;
      r_col_idx  <= 2'd0;
      r_acc_kind <= SwNone;
      r_acc_code <= 4'h0;
    end else if (w_sample) begin
      r_scan_cnt <= '0;
      r_col_idx  <= r_col_idx + 2'd1;
      if (w_sweep_end) begin
        r_acc_kind <= SwNone;
        r_acc_code <= 4'h0;
      end else begin
        r_acc_kind <= w_acc_kind;
        r_acc_code <= w_acc_code;
      end
    end else begin
      r_scan_cnt <= r_scan_cnt + ScanW'(1);
    end
  end

  // MULTI collapses to NONE, so the candidate only needs a single/none flag plus code.
  assign w_res_single = (w_acc_kind == SwSingle);
  assign w_same       = (w_res_single == r_cand_single) &&
                        (!w_res_single || (w_acc_code == r_cand_code));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cand_single <= 1'b0;
      r_cand_code   <= 4'h0;
      r_match_cnt   <= '0;
    end else if (w_sweep_end) begin
      if (w_same) begin
        if (r_match_cnt != DebMax) r_match_cnt <= r_match_cnt + DebW'(1);
      end else begin
        r_cand_single <= w_res_single;
        r_cand_code   <= w_res_single ? w_acc_code : 4'h0;
        r_match_cnt   <= DebW'(1);
      end
    end
  end

  assign w_deb_done = (r_match_cnt == DebMax);

  always_comb begin
    w_state_d       = r_state;
    w_key_val_d     = r_key_val;
    w_key_pressed_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_cand_single && w_deb_done) begin
          w_state_d       = StHeld;
          w_key_val_d     = r_cand_code;
          w_key_pressed_d = 1'b1;
        end
      end
      StHeld: begin
        if (!r_cand_single && w_deb_done) w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_key_val     <= 4'h0;
      r_key_pressed <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_key_val     <= w_key_val_d;
      r_key_pressed <= w_key_pressed_d;
    end
  end

  assign o_col_out     = ~(4'b0001 << r_col_idx);
  assign o_key_val     = r_key_val;
  assign o_key_pressed = r_key_pressed;
  assign o_key_held    = (r_state == StHeld);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix (SCAN_CYCLES=8, DEB_SCANS=3).
module tb_keypad_scanner;

  localparam int unsigned SweepClks = 32;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_val;
  logic        key_pressed;
  logic        key_held;

  logic [15:0] keys;
  int          n_chk;
  int          n_err;
  int          cyc;
  int          pulse_cnt;
  int          pulse_cyc;
  logic        prev_pressed;
  logic        dbl_pulse;
  int          base;
  int          p0;
  logic [3:0]  col_seq [4];

  keypad_scanner #(
    .SCAN_CYCLES (8),
    .DEB_SCANS   (3)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_row_in      (row_in),
    .o_col_out     (col_out),
    .o_key_val     (key_val),
    .o_key_pressed (key_pressed),
    .o_key_held    (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: pressed key at code {row, col} pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    pulse_cnt    = 0;
    pulse_cyc    = -1;
    prev_pressed = 1'b0;
    dbl_pulse    = 1'b0;
  end

  always @(negedge clk) begin
    if (key_pressed) begin
      pulse_cnt <= pulse_cnt + 1;
      pulse_cyc <= cyc;
      if (prev_pressed) dbl_pulse <= 1'b1;
    end
    prev_pressed <= key_pressed;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_sweeps(input int n);
    repeat (n * SweepClks) @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    col_seq[0] = 4'hE;
    col_seq[1] = 4'hD;
    col_seq[2] = 4'hB;
    col_seq[3] = 4'h7;
    keys  = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", col_out, 4'hE);
    chk("rst_val", key_val, 4'h0);
    chk("rst_pressed", key_pressed, 1'b0);
    chk("rst_held", key_held, 1'b0);

    // Column rotation with no key
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("col_0", col_out, col_seq[0]);
    for (int i = 1; i <= 4; i++) begin
      repeat (8) @(negedge clk);
      chk($sformatf("col_step%0d", i), col_out, col_seq[i % 4]);
    end
    run_sweeps(2);
    chk("idle_no_pulse", pulse_cnt, 0);

    // Key 6 (row 1, col 2) pressed and held
    keys = 16'h0040;
    base = cyc;
    run_sweeps(3);
    chk("press6_cnt", pulse_cnt, 1);
    chk("press6_latency", pulse_cyc, base + 95);
    chk("press6_val", key_val, 4'h6);
    chk("press6_held", key_held, 1'b1);
    run_sweeps(10);
    chk("hold6_cnt", pulse_cnt, 1);
    chk("hold6_held", key_held, 1'b1);
    keys = 16'h0000;
    run_sweeps(3);
    chk("rel6_held", key_held, 1'b0);
    chk("rel6_val_kept", key_val, 4'h6);
    chk("rel6_cnt", pulse_cnt, 1);

    // Bounce: alternating SINGLE/NONE sweeps, then stable
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      run_sweeps(1);
    end
    chk("bounce_no_pulse", pulse_cnt, p0);
    keys = 16'h0040;
    base = cyc;
    run_sweeps(2);
    chk("bounce_2stable", pulse_cnt, p0);
    run_sweeps(1);
    chk("bounce_3stable", pulse_cnt, p0 + 1);
    chk("bounce_latency", pulse_cyc, base + 95);
    chk("bounce_val", key_val, 4'h6);
    keys = 16'h0000;
    run_sweeps(3);
    chk("bounce_rel", key_held, 1'b0);

    // Two keys together count as no key
    p0 = pulse_cnt;
    keys = 16'h0104;
    run_sweeps(5);
    chk("multi_no_pulse", pulse_cnt, p0);
    chk("multi_not_held", key_held, 1'b0);
    keys = 16'h0000;
    run_sweeps(1);

    // Switch from 6 to 2 while held, then release and press 2
    keys = 16'h0040;
    run_sweeps(3);
    chk("sw_press6", pulse_cnt, p0 + 1);
    chk("sw_held6", key_held, 1'b1);
    keys = 16'h0004;
    run_sweeps(4);
    chk("sw_to2_no_pulse", pulse_cnt, p0 + 1);
    chk("sw_to2_val", key_val, 4'h6);
    chk("sw_to2_held", key_held, 1'b1);
    keys = 16'h0000;
    run_sweeps(3);
    chk("sw_rel", key_held, 1'b0);
    keys = 16'h0004;
    run_sweeps(3);
    chk("sw_press2", pulse_cnt, p0 + 2);
    chk("sw_val2", key_val, 4'h2);
    chk("sw_held2", key_held, 1'b1);

    // Reset while key 2 is held
    p0 = pulse_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_col", col_out, 4'hE);
    chk("midrst_val", key_val, 4'h0);
    chk("midrst_held", key_held, 1'b0);
    chk("midrst_pressed", key_pressed, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_sweeps(2);
    chk("postrst_2sweeps", pulse_cnt, p0);
    chk("postrst_not_held", key_held, 1'b0);
    run_sweeps(1);
    chk("postrst_pulse", pulse_cnt, p0 + 1);
    chk("postrst_latency", pulse_cyc, 97);
    chk("postrst_val", key_val, 4'h2);
    chk("postrst_held", key_held, 1'b1);

    chk("no_double_pulse", dbl_pulse, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 50000, clocks each column is driven (1 ms at 50 MHz).
REQ-002 Parameter DEB_SCANS, default 5, consecutive identical full sweeps needed to accept a press or release.
REQ-003 clk  input  1  system clock, 50 MHz, rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 col_out  output  4  keypad column drive, active-low, exactly one bit low outside reset.
REQ-007 key_val  output  4  code of the accepted key, {row_idx[1:0], col_idx[1:0]}.
REQ-008 key_pressed  output  1  single-cycle pulse on press acceptance.
REQ-009 key_held  output  1  high while an accepted key has not yet been released.

Function
REQ-010 row_in SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Column counter col_idx (0..3) SHALL drive col_out = ~(4'b0001 << col_idx) and advance, wrapping 3->0, every SCAN_CYCLES clocks.
REQ-012 Synchronized rows SHALL be sampled on the last cycle of each column period; earlier cycles are settle time.
REQ-013 A sweep ends at the column-3 sample; sweep result = NONE (no low row bit), SINGLE(code) (exactly one low bit over all 4 columns), or MULTI (two or more).
REQ-014 MULTI SHALL be treated as NONE.
REQ-015 Debounce: cand register plus match counter (0..DEB_SCANS); a sweep result equal to cand increments the counter (saturating), a differing result loads cand and sets the counter to 1.
REQ-016 FSM states IDLE, HELD.
REQ-017 IDLE -> HELD when cand is SINGLE(c) and the counter reaches DEB_SCANS; on that transition key_val <= c and key_pressed is high for the next cycle only.
REQ-018 HELD -> IDLE when cand is NONE and the counter reaches DEB_SCANS; no pulse on release.
REQ-019 In HELD, a different SINGLE code is ignored (no pulse, key_val unchanged) until release is accepted.
REQ-020 key_held SHALL equal (state == HELD).
REQ-021 key_val SHALL hold its last accepted value through IDLE.
REQ-022 Press latency: key_pressed rises 1 clock after the end of the DEB_SCANS-th consecutive matching sweep.
REQ-023 At most one key_pressed pulse per physical press; key_pressed is never high for 2 consecutive cycles.
REQ-024 Internal counters SHALL be sized by $clog2 of their parameters and never overflow.

Reset
REQ-025 On rst_n low, immediately: col_out = 4'b1110, col_idx = 0, scan counter = 0, synchronizer = 4'b1111, cand = NONE, match counter = 0, state = IDLE, key_val = 0, key_pressed = 0, key_held = 0.
REQ-026 Reset mid-press SHALL discard all debounce history; a key still held after release of reset needs DEB_SCANS fresh sweeps to be accepted.

Structure
REQ-027 Shared package: state encoding (IDLE, HELD), sweep-result encoding, key codes 4'h2/4'h4/4'h6/4'h8 named KEY_RIGHT/KEY_DOWN/KEY_UP/KEY_LEFT for use by the game core.
REQ-028 One sub-module, sync2, SHALL implement the 4-bit 2-flop synchronizer.
REQ-029 key_val/key_pressed SHALL connect directly to the game core's key inputs with no extra glue.

Verification (SCAN_CYCLES=8, DEB_SCANS=3)
REQ-030 Reset, no key -> col_out cycles 1110,1101,1011,0111 every 8 clocks; key_pressed never high.
REQ-031 Row 1 held low while column 2 is driven, for 3 sweeps -> one key_pressed pulse, key_val=4'h6, key_held=1; holding 10 more sweeps -> no further pulse.
REQ-032 Key 4'h6 bouncing (alternating NONE/SINGLE each sweep for 4 sweeps) then stable -> first pulse only after 3 consecutive stable sweeps.
REQ-033 Two keys (codes 2 and 8) held together -> no pulse, key_held=0.
REQ-034 In HELD on 4'h6, switch directly to 4'h2 -> no pulse; release for 3 sweeps then press 4'h2 for 3 sweeps -> pulse, key_val=4'h2.
REQ-035 rst_n asserted during HELD with key still down -> outputs reset at once; after release of reset, pulse reappears only after 3 full sweeps.
